// File: rtl/daq_depacketizer_pkg.sv
// Shared constants and checksum rule for the DAQ frame format.
// The packetizer and this decoder both use them, so the two ends stay consistent.
package daq_depacketizer_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned FCNT_W   = 16;

  localparam int unsigned N_CH_DEF = 8;
  localparam int unsigned CH_W_DEF = 3;

  localparam logic [BYTE_W-1:0] SYNC0_DEF = 8'hA5;
  localparam logic [BYTE_W-1:0] SYNC1_DEF = 8'h5A;

  // Frame layout: SYNC0, SYNC1, SEQ, N_CH x {MSB, LSB}, CSUM.
  localparam int unsigned HDR_BYTES = 3;

  // The checksum is the XOR of SEQ and every sample byte.
  function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/daq_depacketizer.sv
// Rebuilds 16-bit ADC sample frames from the packetizer byte stream on the FIFO read side.
// It finds frame sync, checks the sequence number and checksum, and emits one sample per channel.
module daq_depacketizer
  import daq_depacketizer_pkg::*;
#(
  parameter int unsigned       N_CH  = N_CH_DEF,
  parameter int unsigned       CH_W  = CH_W_DEF,
  parameter logic [BYTE_W-1:0] SYNC0 = SYNC0_DEF,
  parameter logic [BYTE_W-1:0] SYNC1 = SYNC1_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rdreq_o,
  input  logic [BYTE_W-1:0]   fifo_data_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic [CH_W-1:0]     chan_o,
  output logic                sample_valid_o,
  output logic [SEQ_W-1:0]    seq_o,
  output logic                frame_done_o,
  output logic                csum_ok_o,
  output logic                err_sync_o,
  output logic                err_seq_o,
  output logic                err_csum_o,
  output logic [FCNT_W-1:0]   frame_cnt_o
);

  typedef enum logic [2:0] {
    ST_HUNT0 = 3'd0,
    ST_HUNT1 = 3'd1,
    ST_SEQ   = 3'd2,
    ST_MSB   = 3'd3,
    ST_LSB   = 3'd4,
    ST_CSUM  = 3'd5
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic                r_byte_v;
  logic [BYTE_W-1:0]   r_hi;
  logic [BYTE_W-1:0]   r_csum;
  logic [SEQ_W-1:0]    r_exp_seq;
  logic [CH_W-1:0]     r_cnt;
  logic                r_seq_locked;

  logic [BYTE_W-1:0]   w_hi;
  logic [BYTE_W-1:0]   w_csum;
  logic [SEQ_W-1:0]    w_exp_seq;
  logic [CH_W-1:0]     w_cnt;
  logic                w_seq_locked;
  logic [SAMPLE_W-1:0] w_sample;
  logic [CH_W-1:0]     w_chan;
  logic                w_sample_valid;
  logic [SEQ_W-1:0]    w_seq;
  logic                w_frame_done;
  logic                w_csum_ok;
  logic                w_err_sync;
  logic                w_err_seq;
  logic                w_err_csum;
  logic [FCNT_W-1:0]   w_frame_cnt;
  logic                w_csum_match;

  // Read data arrives the cycle after the request, so r_byte_v tracks the request.
  assign fifo_rdreq_o = en_i & ~fifo_empty_i & ~reset_i;
  assign w_csum_match = (fifo_data_i == r_csum);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_HUNT0;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_byte_v) begin
      case (r_state)
        ST_HUNT0: if (fifo_data_i == SYNC0) w_state_nxt = ST_HUNT1;
        ST_HUNT1: begin
          if (fifo_data_i == SYNC1)      w_state_nxt = ST_SEQ;
          else if (fifo_data_i != SYNC0) w_state_nxt = ST_HUNT0;
        end
        ST_SEQ:   w_state_nxt = ST_MSB;
        ST_MSB:   w_state_nxt = ST_LSB;
        ST_LSB:   w_state_nxt = (r_cnt == LAST_CH) ? ST_CSUM : ST_MSB;
        ST_CSUM:  w_state_nxt = ST_HUNT0;
        default:  w_state_nxt = ST_HUNT0;
      endcase
    end
  end

  always_comb begin
    w_hi           = r_hi;
    w_csum         = r_csum;
    w_exp_seq      = r_exp_seq;
    w_cnt          = r_cnt;
    w_seq_locked   = r_seq_locked;
    w_sample       = sample_o;
    w_chan         = chan_o;
    w_seq          = seq_o;
    w_csum_ok      = csum_ok_o;
    w_frame_cnt    = frame_cnt_o;
    w_sample_valid = 1'b0;
    w_frame_done   = 1'b0;
    w_err_sync     = 1'b0;
    w_err_seq      = 1'b0;
    w_err_csum     = 1'b0;
    if (r_byte_v) begin
      case (r_state)
        ST_HUNT0: w_err_sync = (fifo_data_i != SYNC0);
        ST_HUNT1: w_err_sync = (fifo_data_i != SYNC1) && (fifo_data_i != SYNC0);
        ST_SEQ: begin
          w_seq     = fifo_data_i;
          w_csum    = fifo_data_i;
          w_cnt     = '0;
          w_err_seq = r_seq_locked && (fifo_data_i != r_exp_seq);
          // Expected sequence always follows the byte just received.
          w_exp_seq = fifo_data_i + 8'd1;
        end
        ST_MSB: begin
          w_hi   = fifo_data_i;
          w_csum = csum_step(r_csum, fifo_data_i);
        end
        ST_LSB: begin
          w_sample       = {r_hi, fifo_data_i};
          w_chan         = r_cnt;
          w_sample_valid = 1'b1;
          w_csum         = csum_step(r_csum, fifo_data_i);
          if (r_cnt != LAST_CH) w_cnt = r_cnt + CH_W'(1);
        end
        ST_CSUM: begin
          w_frame_done = 1'b1;
          w_csum_ok    = w_csum_match;
          if (w_csum_match) begin
            w_seq_locked = 1'b1;
            w_frame_cnt  = frame_cnt_o + FCNT_W'(1);
          end else begin
            w_err_csum   = 1'b1;
            w_seq_locked = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_byte_v       <= 1'b0;
      r_hi           <= '0;
      r_csum         <= '0;
      r_exp_seq      <= '0;
      r_cnt          <= '0;
      r_seq_locked   <= 1'b0;
      sample_o       <= '0;
      chan_o         <= '0;
      sample_valid_o <= 1'b0;
      seq_o          <= '0;
      frame_done_o   <= 1'b0;
      csum_ok_o      <= 1'b0;
      err_sync_o     <= 1'b0;
      err_seq_o      <= 1'b0;
      err_csum_o     <= 1'b0;
      frame_cnt_o    <= '0;
    end else begin
      r_byte_v       <= fifo_rdreq_o;
      r_hi           <= w_hi;
      r_csum         <= w_csum;
      r_exp_seq      <= w_exp_seq;
      r_cnt          <= w_cnt;
      r_seq_locked   <= w_seq_locked;
      sample_o       <= w_sample;
      chan_o         <= w_chan;
      sample_valid_o <= w_sample_valid;
      seq_o          <= w_seq;
      frame_done_o   <= w_frame_done;
      csum_ok_o      <= w_csum_ok;
      err_sync_o     <= w_err_sync;
      err_seq_o      <= w_err_seq;
      err_csum_o     <= w_err_csum;
      frame_cnt_o    <= w_frame_cnt;
    end
  end

endmodule
